wb_cfg_sequencer: RTL

Synthesizable Wishbone classic single-cycle master that sits directly upstream of the ethmac register slave port (`wb_*_i` / `wb_*_o` side). It accepts register-access commands over a valid/ready stream and issues one Wishbone cycle per command. It bounds each cycle with an ack timeout and returns a status/read-data response over a second valid/ready stream. It replaces bench-level write tasks with hardware that works identically in RTL and gate-level runs.

---
 rtl/wb_seq_pkg.sv | 20 ++
 rtl/wb_seq_timer.sv | 29 ++
 rtl/wb_cfg_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/wb_seq_pkg.sv
// Shared definitions for the Wishbone configuration sequencer.
// GAP exists in the state encoding only when WB_SEQ_RETRY_EN is defined.
package wb_seq_pkg;

  localparam int unsigned WB_SEQ_TMR_W = 16;

  localparam logic [1:0] WB_SEQ_OK      = 2'b00;
  localparam logic [1:0] WB_SEQ_ERR     = 2'b01;
  localparam logic [1:0] WB_SEQ_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
`ifdef WB_SEQ_RETRY_EN
    ST_GAP  = 2'd2,
`endif
    ST_RESP = 2'd3
  } seq_state_e;

endpackage

// File: rtl/wb_seq_timer.sv
// Clear/enable cycle counter with a terminal-count flag at TIMEOUT_CYC-1.
module wb_seq_timer
  import wb_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [WB_SEQ_TMR_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // The sequencer leaves BUS on the edge where tc is seen, so count never wraps.
  assign tc = (count == WB_SEQ_TMR_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_cfg_sequencer.sv
// Wishbone classic single-cycle master driven by a command/response stream pair.
// Define WB_SEQ_RETRY_EN to re-issue failed cycles up to MAX_RETRY times.
module wb_cfg_sequencer
  import wb_seq_pkg::*;
#(
  parameter int unsigned ADR_W       = 10,
  parameter int unsigned TIMEOUT_CYC = 40,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [31:0]      cmd_dat_i,
  input  logic [3:0]       cmd_sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_dat_o,
  output logic [1:0]       rsp_status_o,
  output logic [1:0]       rsp_retries_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535 || MAX_RETRY > 3) begin : g_param_check
    $error("wb_cfg_sequencer: TIMEOUT_CYC or MAX_RETRY out of range");
  end

  seq_state_e       state_q, state_d;
  logic             cmd_ready_d, rsp_valid_d, wb_cyc_d;
  logic [31:0]      rsp_dat_d;
  logic [1:0]       rsp_status_d;
  logic [ADR_W-1:0] wb_adr_d;
  logic [31:0]      wb_dat_d;
  logic [3:0]       wb_sel_d;
  logic             wb_we_d;
  logic             tmr_clr, tmr_en, tmr_tc;

  wb_seq_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_n_i),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .tc   (tmr_tc)
  );

`ifdef WB_SEQ_RETRY_EN
  logic [1:0] retry_q, retry_d;
  logic       retry_ok;

  assign retry_ok = (32'(retry_q) < MAX_RETRY);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end

  assign rsp_retries_o = retry_q;
`else
  assign rsp_retries_o = 2'b00;
`endif

  always_comb begin
    state_d      = state_q;
    rsp_dat_d    = rsp_dat_o;
    rsp_status_d = rsp_status_o;
    wb_adr_d     = wb_adr_o;
    wb_dat_d     = wb_dat_o;
    wb_sel_d     = wb_sel_o;
    wb_we_d      = wb_we_o;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
`ifdef WB_SEQ_RETRY_EN
    retry_d      = retry_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          wb_adr_d = cmd_adr_i;
          wb_dat_d = cmd_dat_i;
          wb_sel_d = cmd_sel_i;
          wb_we_d  = cmd_we_i;
          tmr_clr  = 1'b1;
          state_d  = ST_BUS;
`ifdef WB_SEQ_RETRY_EN
          retry_d  = '0;
`endif
        end
      end

      // ack wins over err, err wins over the timeout.
      ST_BUS: begin
        tmr_en = 1'b1;
        if (wb_ack_i) begin
          rsp_status_d = WB_SEQ_OK;
          rsp_dat_d    = wb_we_o ? 32'd0 : wb_dat_i;
          state_d      = ST_RESP;
        end else if (wb_err_i || tmr_tc) begin
          rsp_status_d = wb_err_i ? WB_SEQ_ERR : WB_SEQ_TIMEOUT;
          rsp_dat_d    = 32'd0;
`ifdef WB_SEQ_RETRY_EN
          state_d      = retry_ok ? ST_GAP : ST_RESP;
`else
          state_d      = ST_RESP;
`endif
        end
      end

`ifdef WB_SEQ_RETRY_EN
      ST_GAP: begin
        retry_d = retry_q + 2'd1;
        tmr_clr = 1'b1;
        state_d = ST_BUS;
      end
`endif

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    wb_cyc_d    = (state_d == ST_BUS);
  end

  // Every output is a flop fed from the next-state decode above.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= ST_IDLE;
      cmd_ready_o  <= 1'b1;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= WB_SEQ_OK;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      wb_we_o      <= 1'b0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_o  <= cmd_ready_d;
      rsp_valid_o  <= rsp_valid_d;
      rsp_dat_o    <= rsp_dat_d;
      rsp_status_o <= rsp_status_d;
      wb_adr_o     <= wb_adr_d;
      wb_dat_o     <= wb_dat_d;
      wb_sel_o     <= wb_sel_d;
      wb_we_o      <= wb_we_d;
      wb_cyc_o     <= wb_cyc_d;
      wb_stb_o     <= wb_cyc_d;
    end
  end

endmodule
